csr_reg_file: RTL

- Machine-mode CSR register file and trap unit for the 3-stage RV32I pipeline.
- Acts on the decoder's csr_rd / csr_wr / is_mret strobes.
- Holds mstatus, mie, mip, mtvec, mepc and mcause.
- Detects timer and external interrupts, and issues a one-cycle PC redirect on trap entry and on mret.

---
 rtl/csr_reg_file.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/csr_reg_file.sv
// Machine-mode CSR file and trap unit: mstatus/mie/mip/mtvec/mepc/mcause, interrupt entry and mret redirect.
// Optional 64-bit mcycle/mcycleh counter is enabled by defining CSR_MCYCLE_EN.
module csr_reg_file #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_rd,
  input  logic            csr_wr,
  input  logic            is_mret,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] pc,
  input  logic            timer_irq,
  input  logic            ext_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic            epc_taken,
  output logic [XLEN-1:0] epc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TRAP = 2'd1;
  localparam logic [1:0] S_RET  = 2'd2;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam logic [11:0] A_MCYCLE  = 12'hB00;
  localparam logic [11:0] A_MCYCLEH = 12'hB80;

  logic [1:0]             r_state;
  logic                   r_mstatusMie;
  logic                   r_mstatusMpie;
  logic                   r_mieMtie;
  logic                   r_mieMeie;
  logic [XLEN-1:2]        r_mtvecBase;
  logic                   r_mtvecMode;
  logic [XLEN-1:0]        r_mepc;
  logic [XLEN-1:0]        r_mcause;
  logic [3:0]             r_trapCode;
  logic                   r_mipMtip;
  logic [SYNC_STAGES-1:0] r_extSync;

  logic                   w_meip;
  logic                   w_extHit;
  logic                   w_irqPend;
  logic [3:0]             w_trapCode;
  logic                   w_wrEn;
  logic [XLEN-1:0]        w_mstatus;
  logic [XLEN-1:0]        w_mie;
  logic [XLEN-1:0]        w_mip;
  logic [XLEN-1:0]        w_mtvec;
  logic [XLEN-1:0]        w_trapBase;

  assign w_meip     = r_extSync[SYNC_STAGES-1];
  assign w_extHit   = w_meip & r_mieMeie;
  assign w_irqPend  = r_mstatusMie & (w_extHit | (r_mipMtip & r_mieMtie));
  assign w_trapCode = w_extHit ? 4'd11 : 4'd7;
  assign w_wrEn     = (r_state == S_IDLE) && csr_wr && !is_mret;

  assign w_mstatus  = {{(XLEN-8){1'b0}}, r_mstatusMpie, 3'b000, r_mstatusMie, 3'b000};
  assign w_mie      = {{(XLEN-12){1'b0}}, r_mieMeie, 3'b000, r_mieMtie, 7'b0000000};
  assign w_mip      = {{(XLEN-12){1'b0}}, w_meip, 3'b000, r_mipMtip, 7'b0000000};
  assign w_mtvec    = {r_mtvecBase, 1'b0, r_mtvecMode};
  assign w_trapBase = {r_mtvecBase, 2'b00};

  // ext_irq is asynchronous and needs the full synchroniser; timer_irq is already in this domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_extSync <= '0;
      r_mipMtip <= 1'b0;
    end else begin
      r_extSync <= {r_extSync[SYNC_STAGES-2:0], ext_irq};
      r_mipMtip <= timer_irq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_mstatusMie  <= 1'b0;
      r_mstatusMpie <= 1'b0;
      r_mieMtie     <= 1'b0;
      r_mieMeie     <= 1'b0;
      r_mtvecBase   <= '0;
      r_mtvecMode   <= 1'b0;
      r_mepc        <= '0;
      r_mcause      <= '0;
      r_trapCode    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (is_mret) begin
            r_mstatusMie  <= r_mstatusMpie;
            r_mstatusMpie <= 1'b1;
            r_state       <= S_RET;
          end else if (csr_wr) begin
            case (csr_addr)
              A_MSTATUS: begin
                r_mstatusMie  <= csr_wdata[3];
                r_mstatusMpie <= csr_wdata[7];
              end
              A_MIE: begin
                r_mieMtie <= csr_wdata[7];
                r_mieMeie <= csr_wdata[11];
              end
              A_MTVEC: begin
                r_mtvecBase <= csr_wdata[XLEN-1:2];
                r_mtvecMode <= (csr_wdata[1:0] == 2'b01);
              end
              A_MEPC:   r_mepc   <= {csr_wdata[XLEN-1:2], 2'b00};
              A_MCAUSE: r_mcause <= csr_wdata;
              default: ;
            endcase
          end else if (w_irqPend) begin
            r_mepc        <= pc;
            r_mstatusMpie <= r_mstatusMie;
            r_mstatusMie  <= 1'b0;
            r_mcause      <= {1'b1, {(XLEN-5){1'b0}}, w_trapCode};
            r_trapCode    <= w_trapCode;
            r_state       <= S_TRAP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CSR_MCYCLE_EN
  logic [2*XLEN-1:0] r_mcycle;

  // A write to one half holds the other half and suppresses that cycle's increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcycle <= '0;
    end else if (w_wrEn && csr_addr == A_MCYCLE) begin
      r_mcycle[XLEN-1:0] <= csr_wdata;
    end else if (w_wrEn && csr_addr == A_MCYCLEH) begin
      r_mcycle[2*XLEN-1:XLEN] <= csr_wdata;
    end else begin
      r_mcycle <= r_mcycle + 1'b1;
    end
  end
`endif

  always_comb begin
    csr_rdata = '0;
    if (csr_rd) begin
      case (csr_addr)
        A_MSTATUS: csr_rdata = w_mstatus;
        A_MIE:     csr_rdata = w_mie;
        A_MTVEC:   csr_rdata = w_mtvec;
        A_MEPC:    csr_rdata = r_mepc;
        A_MCAUSE:  csr_rdata = r_mcause;
        A_MIP:     csr_rdata = w_mip;
`ifdef CSR_MCYCLE_EN
        A_MCYCLE:  csr_rdata = r_mcycle[XLEN-1:0];
        A_MCYCLEH: csr_rdata = r_mcycle[2*XLEN-1:XLEN];
`endif
        default:   csr_rdata = '0;
      endcase
    end
  end

  always_comb begin
    epc_taken = 1'b0;
    epc       = '0;
    case (r_state)
      S_TRAP: begin
        epc_taken = 1'b1;
        epc       = r_mtvecMode ? (w_trapBase + {{(XLEN-6){1'b0}}, r_trapCode, 2'b00}) : w_trapBase;
      end
      S_RET: begin
        epc_taken = 1'b1;
        epc       = r_mepc;
      end
      default: ;
    endcase
  end

endmodule
